acia_lite: RTL and testbench

//  Minimal ACIA-compatible 8N1 UART peripheral; the responder at the far end of the mmu's acia_ce_n select.
//  - CPU bus side: 2-bit register select, 8-bit data.
//  - Line side: TX/RX serial lines at a fixed bit rate.
//  - Raises active-low IRQ on RX-full or TX-empty when enabled.

---
 rtl/acia_pkg.sv | 28 ++
 rtl/acia_lite_rx.sv | 110 +++++++++++
 rtl/acia_lite.sv | 217 +++++++++++++++++++++
 tb/tb_acia_lite.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// Shared register map, status/command bit positions and serial FSM states
// for the acia_lite UART and its receiver.
package acia_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] REG_DATA   = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;
  localparam logic [1:0] REG_CMD    = 2'b10;
  localparam logic [1:0] REG_RSVD   = 2'b11;

  localparam logic [2:0] ST_FE   = 3'd1;
  localparam logic [2:0] ST_OVR  = 3'd2;
  localparam logic [2:0] ST_RDRF = 3'd3;
  localparam logic [2:0] ST_TDRE = 3'd4;
  localparam logic [2:0] ST_IRQ  = 3'd7;

  localparam logic [2:0] CMD_RXIE = 3'd0;
  localparam logic [2:0] CMD_TXIE = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/acia_lite_rx.sv
// 8N1 receiver: 2-FF synchronizer, falling-edge start detect and mid-bit
// sampling; delivers the byte with a one-cycle done strobe and framing error.
module acia_lite_rx
  import acia_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd_i,
  output logic [DATA_W-1:0] byte_o,
  output logic              done_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // [1:0] synchronizer stages, [2] previous synchronized sample
  logic [2:0]        sync_q;
  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              done_q, done_d;
  logic              fe_q, fe_d;
  logic              rx_c, fall_c;

  assign rx_c   = sync_q[1];
  assign fall_c = sync_q[2] & ~sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    fe_d    = fe_q;
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          cnt_d   = HALF_LAST;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_c) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = BIT_LAST;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_c, shift_q[DATA_W-1:1]};
          cnt_d   = BIT_LAST;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          byte_d  = shift_q;
          fe_d    = ~rx_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o      = byte_q;
  assign done_o      = done_q;
  assign frame_err_o = fe_q;

endmodule

// File: rtl/acia_lite.sv
// Minimal ACIA-style 8N1 UART: CPU register file, transmitter FSM and
// interrupt logic; reception is delegated to acia_lite_rx.
module acia_lite
  import acia_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_n,
  input  logic       bus_en,
  input  logic       rw,
  input  logic [1:0] rs,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  ser_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              txd_q, txd_d;
  logic              tdre_q, tdre_d;
  logic              tx_load_c;

  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic              rdrf_q, rdrf_d;
  logic              ovr_q, ovr_d;
  logic              fe_q, fe_d;
  logic              irq_n_q;

  logic [DATA_W-1:0] rx_byte;
  logic              rx_done, rx_fe;
  logic              access_c, rd_c, wr_c, irq_c;
  logic [DATA_W-1:0] status_c;

  assign access_c = ~ce_n & bus_en;
  assign rd_c     = access_c & rw;
  assign wr_c     = access_c & ~rw;

  acia_lite_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rxd_i       (rxd),
    .byte_o      (rx_byte),
    .done_o      (rx_done),
    .frame_err_o (rx_fe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      txd_q      <= 1'b1;
      tdre_q     <= 1'b1;
      rx_data_q  <= '0;
      cmd_q      <= '0;
      rdrf_q     <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      irq_n_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      txd_q      <= txd_d;
      tdre_q     <= tdre_d;
      rx_data_q  <= rx_data_d;
      cmd_q      <= cmd_d;
      rdrf_q     <= rdrf_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      irq_n_q    <= ~irq_c;
    end
  end

  // Transmitter; a pending byte at end of STOP chains straight into START.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    txd_d      = txd_q;
    tdre_d     = tdre_q;
    tx_load_c  = 1'b0;
    case (tx_state_q)
      IDLE: begin
        txd_d     = 1'b1;
        tx_load_c = ~tdre_q;
      end
      START: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_state_d = DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      DATA: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_cnt_d = BIT_LAST;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            txd_d      = 1'b1;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else if (!tdre_q) begin
          tx_load_c = 1'b1;
        end else begin
          tx_state_d = IDLE;
          txd_d      = 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    if (tx_load_c) begin
      tx_state_d = START;
      tx_cnt_d   = BIT_LAST;
      tx_shift_d = hold_q;
      tdre_d     = 1'b1;
      txd_d      = 1'b0;
    end
    // A CPU write on the load edge leaves the new byte pending behind the old one.
    if (wr_c && rs == REG_DATA) begin
      hold_d = data_in;
      tdre_d = 1'b0;
    end
  end

  // CPU clears are applied before RX completion so a same-edge read loses nothing.
  always_comb begin
    rx_data_d = rx_data_q;
    cmd_d     = cmd_q;
    rdrf_d    = rdrf_q;
    ovr_d     = ovr_q;
    fe_d      = fe_q;
    if (rd_c && rs == REG_DATA) begin
      rdrf_d = 1'b0;
      ovr_d  = 1'b0;
      fe_d   = 1'b0;
    end
    if (wr_c) begin
      case (rs)
        REG_STATUS: begin
          cmd_d = '0;
          ovr_d = 1'b0;
          fe_d  = 1'b0;
        end
        REG_CMD: cmd_d = data_in;
        default: ;
      endcase
    end
    if (rx_done) begin
      if (rx_fe) fe_d = 1'b1;
      if (rdrf_d) begin
        ovr_d = 1'b1;
      end else begin
        rx_data_d = rx_byte;
        rdrf_d    = 1'b1;
      end
    end
  end

  assign irq_c = (cmd_q[CMD_RXIE] & rdrf_q) | (cmd_q[CMD_TXIE] & tdre_q);

  always_comb begin
    status_c          = '0;
    status_c[ST_IRQ]  = irq_c;
    status_c[ST_TDRE] = tdre_q;
    status_c[ST_RDRF] = rdrf_q;
    status_c[ST_OVR]  = ovr_q;
    status_c[ST_FE]   = fe_q;
  end

  always_comb begin
    data_out = '0;
    if (!ce_n) begin
      case (rs)
        REG_DATA:   data_out = rx_data_q;
        REG_STATUS: data_out = status_c;
        REG_CMD:    data_out = cmd_q;
        REG_RSVD:   data_out = '0;
        default:    data_out = '0;
      endcase
    end
  end

  assign irq_n = irq_n_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_acia_lite.sv
// Directed and randomized bench for acia_lite against a flag/queue-level
// model of the UART register behaviour and serial framing.
`timescale 1ns/1ps
module tb_acia_lite;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset, ce_n, bus_en, rw, rxd;
  logic [1:0] rs;
  logic [7:0] data_in, data_out;
  logic       irq_n, txd;

  int total = 0;
  int bad   = 0;

  logic [7:0] rd;
  logic       irq_snap;

  // Model of the CPU-visible state
  logic       m_rdrf, m_ovr, m_fe;
  logic [7:0] m_data, m_cmd;

  acia_lite #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .ce_n     (ce_n),
    .bus_en   (bus_en),
    .rw       (rw),
    .rs       (rs),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_n    (irq_n),
    .txd      (txd),
    .rxd      (rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  // One bus cycle starting at a negedge; data_out sampled before the access edge.
  task automatic bus(input logic r, input logic [1:0] a, input logic [7:0] wd);
    ce_n = 1'b0; bus_en = 1'b1; rw = r; rs = a; data_in = wd;
    #1;
    rd = data_out;
    irq_snap = irq_n;
    @(negedge clk);
    ce_n = 1'b1; bus_en = 1'b0; rw = 1'b1;
  endtask

  task automatic model_reset();
    m_rdrf = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_data = 8'h00; m_cmd = 8'h00;
  endtask

  function automatic logic [7:0] exp_status(input logic tdre);
    logic irq;
    irq = (m_cmd[0] & m_rdrf) | (m_cmd[1] & tdre);
    return {irq, 2'b00, tdre, m_rdrf, m_ovr, m_fe, 1'b0};
  endfunction

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) m_fe = 1'b1;
    if (m_rdrf) m_ovr = 1'b1;
    else begin m_data = b; m_rdrf = 1'b1; end
  endtask

  task automatic check_data_read(input string tag);
    bus(1'b1, 2'b00, 8'h00);
    check(tag, rd, m_data);
    m_rdrf = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
  endtask

  task automatic check_status(input string tag);
    bus(1'b1, 2'b01, 8'h00);
    check(tag, rd, exp_status(1'b1));
  endtask

  task automatic send_bits(input logic [7:0] b);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits(b);
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [19:0] stream;
    logic [7:0]  b, b2, blost, es;
    logic        stp, eirq;
    int          t, seen, zeros;

    reset = 1'b1; ce_n = 1'b1; bus_en = 1'b0; rw = 1'b1; rs = 2'b00;
    data_in = 8'h00; rxd = 1'b1;
    model_reset();
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_txd", txd, 1'b1);
    check("rst_irq_n", irq_n, 1'b1);
    check_status("rst_status");
    bus(1'b1, 2'b00, 8'h00); check("rst_rxdata", rd, 8'h00);
    bus(1'b1, 2'b10, 8'h00); check("rst_cmd", rd, 8'h00);
    bus(1'b1, 2'b11, 8'h00); check("rsvd_read", rd, 8'h00);

    // TX: A5 then a back-to-back byte; an intermediate write is overwritten
    b2 = 8'($urandom);
    blost = 8'($urandom);
    stream = {1'b1, b2, 1'b0, 1'b1, 8'hA5, 1'b0};
    bus(1'b0, 2'b00, 8'hA5);
    bus(1'b1, 2'b01, 8'h00); check("tdre_before_load", rd, 8'h00);
    bus(1'b1, 2'b01, 8'h00); check("tdre_after_load", rd, 8'h10);
    t = 1;
    while (t < 20 * CPB - 1) begin
      if (t == 3 * CPB)      bus(1'b0, 2'b00, blost);
      else if (t == 5 * CPB) bus(1'b0, 2'b00, b2);
      else                   @(negedge clk);
      t++;
      if (t % CPB == CPB / 2)
        check($sformatf("tx_bit%0d", t / CPB), txd, stream[t / CPB]);
    end
    repeat (CPB / 2 + 2) @(negedge clk);
    check("tx_idle_after", txd, 1'b1);
    check_status("tx_status_after");

    // RX directed
    send_frame(8'h3C, 1'b1); model_rx(8'h3C, 1'b1);
    check_status("rx_status_full");
    check_data_read("rx_data_3c");
    check_status("rx_status_clear");

    send_frame(8'h11, 1'b1); model_rx(8'h11, 1'b1);
    send_frame(8'h22, 1'b1); model_rx(8'h22, 1'b1);
    check_status("ovr_status");
    check_data_read("ovr_data");
    check_status("ovr_status_clear");

    // Accesses without ce_n/bus_en must not clear flags
    b = 8'($urandom);
    send_frame(b, 1'b1); model_rx(b, 1'b1);
    ce_n = 1'b1; bus_en = 1'b1; rw = 1'b1; rs = 2'b00;
    #1; check("ce_n_high_out", data_out, 8'h00);
    @(negedge clk);
    ce_n = 1'b0; bus_en = 1'b0;
    #1; check("bus_en_low_out", data_out, b);
    @(negedge clk);
    ce_n = 1'b1;
    check_status("no_access_status");
    check_data_read("no_access_data");

    // Framing error and programmed reset
    bus(1'b0, 2'b10, 8'hFC); m_cmd = 8'hFC;
    bus(1'b1, 2'b10, 8'h00); check("cmd_readback", rd, 8'hFC);
    send_frame(8'h55, 1'b0); model_rx(8'h55, 1'b0);
    check_status("fe_status");
    bus(1'b0, 2'b01, 8'h00); m_cmd = 8'h00; m_ovr = 1'b0; m_fe = 1'b0;
    check_status("prog_reset_status");
    bus(1'b1, 2'b10, 8'h00); check("prog_reset_cmd", rd, 8'h00);
    check_data_read("fe_data");
    check_status("fe_status_clear");

    // RX interrupt latency
    bus(1'b0, 2'b10, 8'h01); m_cmd = 8'h01;
    @(negedge clk);
    check("rxie_no_irq", irq_n, 1'b1);
    b = 8'($urandom);
    send_bits(b);
    seen = 0;
    for (int c = 0; c < int'(CPB); c++) begin
      rxd = 1'b1;
      bus(1'b1, 2'b01, 8'h00);
      if (seen == 1) begin check("irq_n_next_cycle", irq_snap, 1'b0); seen = 2; end
      if (seen == 0 && rd[3]) begin check("irq_n_same_cycle", irq_snap, 1'b1); seen = 1; end
    end
    check("rdrf_seen", 8'(seen), 8'd2);
    model_rx(b, 1'b1);
    check_status("irq_status");
    check("irq_n_low", irq_n, 1'b0);
    check_data_read("irq_data");
    @(negedge clk);
    check("irq_n_released", irq_n, 1'b1);
    bus(1'b0, 2'b10, 8'h02); m_cmd = 8'h02;
    @(negedge clk);
    check("txie_irq_n", irq_n, 1'b0);
    check_status("txie_status");

    // Randomized frames, reads and command writes
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      stp = ($urandom_range(3) != 0);
      send_frame(b, stp); model_rx(b, stp);
      check_status($sformatf("rand%0d_status", i));
      if ($urandom_range(1) == 1) check_data_read($sformatf("rand%0d_data", i));
      bus(1'b0, 2'b10, 8'($urandom)); m_cmd = data_in;
      @(negedge clk);
      es = exp_status(1'b1);
      eirq = ~es[7];
      check($sformatf("rand%0d_irq_n", i), irq_n, eirq);
    end

    // Reset during TX data bit 3 of A5 (a 0 bit)
    bus(1'b0, 2'b10, 8'h00);
    bus(1'b0, 2'b00, 8'hA5);
    repeat (4 * CPB + CPB / 2 + 1) @(negedge clk);
    check("tx_bit3_before_reset", txd, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("tx_reset_txd", txd, 1'b1);
    reset = 1'b0;
    model_reset();
    check_status("tx_reset_status");
    zeros = 0;
    repeat (11 * CPB) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check("tx_reset_stays_idle", 8'(zeros), 8'd0);

    // Reset mid RX frame discards the partial byte
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1; rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check_status("rx_reset_status");
    check_data_read("rx_reset_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
